// File: rtl/inline_write_control_pkg.sv
// Shared types and buffer indexing for the inline line-buffer controllers.
// The read-side controller uses the same indexing, so lines round-trip.
package inline_write_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int ROW_STRIDE  = 1;
  localparam int LANE_STRIDE = 1;

  function automatic int buf_idx(input int row, input int lane,
                                 input int xmac);
    return row * ROW_STRIDE * xmac + lane * LANE_STRIDE;
  endfunction

endpackage

// File: rtl/inline_write_control_lane_addr.sv
// Per-lane write address registers with load and single-lane increment.
// The selected lane's address is presented combinationally.
module inline_lane_addr
  import inline_write_control_pkg::*;
#(
  parameter int X_MAC    = 4,
  parameter int ADDR_LEN = 13,
  parameter int LW       = (X_MAC > 1) ? $clog2(X_MAC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_load,
  input  logic [ADDR_LEN*X_MAC-1:0] i_st_addr,
  input  logic                      i_inc,
  input  logic [LW-1:0]             i_lane,
  output logic [ADDR_LEN-1:0]       o_cur_addr
);

  logic [ADDR_LEN-1:0] r_addr [X_MAC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < X_MAC; j++)
        r_addr[j] <= '0;
    end else if (i_load) begin
      for (int j = 0; j < X_MAC; j++)
        r_addr[j] <= i_st_addr[j*ADDR_LEN +: ADDR_LEN];
    end else if (i_inc) begin
      r_addr[i_lane] <= r_addr[i_lane] + ADDR_LEN'(1);
    end
  end

  assign o_cur_addr = r_addr[i_lane];

endmodule

// File: rtl/inline_write_control.sv
// Write-side controller: turns a line command plus row beats
// into per-buffer dina/addra/wea for the mesh x mac array.
module inline_write_control
  import inline_write_control_pkg::*;
#(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int ADDR_LEN     = 13,
  parameter int DATA_LEN     = 32,
  parameter int MAX_LINE_LEN = 10,
  parameter int BUFFER_NUM   = X_MAC * X_MESH,
  parameter int DATAWIDTH    = BUFFER_NUM * DATA_LEN,
  parameter int ADDRWIDTH    = BUFFER_NUM * ADDR_LEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_LEN*X_MAC-1:0]  st_addr,
  input  logic [MAX_LINE_LEN-1:0]    linelen,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [X_MESH*DATA_LEN-1:0] in_data,
  output logic [DATAWIDTH-1:0]       dina,
  output logic [ADDRWIDTH-1:0]       addra,
  output logic [BUFFER_NUM-1:0]      wea,
  output logic                       busy,
  output logic                       done
);

  localparam int LW = (X_MAC > 1) ? $clog2(X_MAC) : 1;

  state_e                  r_state;
  logic [LW-1:0]           r_lane;
  logic [MAX_LINE_LEN-1:0] r_rem;
  logic [DATAWIDTH-1:0]    r_dina;
  logic [ADDRWIDTH-1:0]    r_addra;
  logic [BUFFER_NUM-1:0]   r_wea;
  logic                    r_done;

  logic                w_load;
  logic                w_inc;
  logic [ADDR_LEN-1:0] w_cur_addr;
  logic [LW-1:0]       w_lane_nxt;

  assign w_load = (r_state == ST_IDLE) && cmd_valid;
  assign w_inc  = (r_state == ST_WRITE) && in_valid;

  assign w_lane_nxt = (r_lane == LW'(X_MAC - 1)) ? '0
                    : r_lane + LW'(1);

  inline_lane_addr #(
    .X_MAC    (X_MAC),
    .ADDR_LEN (ADDR_LEN),
    .LW       (LW)
  ) u_lane_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_st_addr  (st_addr),
    .i_inc      (w_inc),
    .i_lane     (r_lane),
    .o_cur_addr (w_cur_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lane  <= '0;
      r_rem   <= '0;
      r_dina  <= '0;
      r_addra <= '0;
      r_wea   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_wea  <= '0;
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_lane <= '0;
            r_rem  <= linelen;
            if (linelen == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (in_valid) begin
            for (int i = 0; i < X_MESH; i++) begin
              r_wea[buf_idx(i, int'(r_lane), X_MAC)] <= 1'b1;
              r_dina[buf_idx(i, int'(r_lane), X_MAC)*DATA_LEN +: DATA_LEN]
                <= in_data[i*DATA_LEN +: DATA_LEN];
              r_addra[buf_idx(i, int'(r_lane), X_MAC)*ADDR_LEN +: ADDR_LEN]
                <= w_cur_addr;
            end
            r_lane <= w_lane_nxt;
            r_rem  <= r_rem - MAX_LINE_LEN'(1);
            // Final beat: done lands alongside its wea.
            if (r_rem == MAX_LINE_LEN'(1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign in_ready  = (r_state == ST_WRITE);
  assign busy      = (r_state != ST_IDLE);
  assign dina      = r_dina;
  assign addra     = r_addra;
  assign wea       = r_wea;
  assign done      = r_done;

endmodule

// File: tb/tb_inline_write_control.sv
// Scoreboard bench for inline_write_control (4 lanes x 2 rows).
// Expected writes are queued at beat accept and checked on wea.
module tb_inline_write_control;

  localparam int XM = 4;
  localparam int XR = 2;
  localparam int AL = 13;
  localparam int DL = 32;
  localparam int LL = 10;
  localparam int BN = XM * XR;

  typedef struct {
    int            lane;
    logic [AL-1:0] addr;
    logic [XR*DL-1:0] data;
    logic          last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [AL*XM-1:0] st_addr = '0;
  logic [LL-1:0]   linelen = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XR*DL-1:0] in_data = '0;
  logic [BN*DL-1:0] dina;
  logic [BN*AL-1:0] addra;
  logic [BN-1:0]   wea;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  exp_t q[$];
  logic [AL-1:0] log0[$];
  logic [AL-1:0] log3[$];

  logic [AL-1:0] m_addr [XM];
  int            m_lane;
  int            m_rem;

  inline_write_control #(
    .X_MAC        (XM),
    .X_MESH       (XR),
    .ADDR_LEN     (AL),
    .DATA_LEN     (DL),
    .MAX_LINE_LEN (LL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .st_addr   (st_addr),
    .linelen   (linelen),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dina      (dina),
    .addra     (addra),
    .wea       (wea),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && wea !== '0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wea got %h required none", wea);
      end else begin
        exp_t e;
        logic [BN-1:0] ew;
        e = q.pop_front();
        ew = '0;
        for (int i = 0; i < XR; i++) ew[i*XM + e.lane] = 1'b1;
        checks++;
        if (wea !== ew) begin
          errors++;
          $display("FAIL wea got %h required %h", wea, ew);
        end
        for (int i = 0; i < XR; i++) begin
          int b;
          b = i*XM + e.lane;
          checks++;
          if (dina[b*DL +: DL] !== e.data[i*DL +: DL]) begin
            errors++;
            $display("FAIL dina[%0d] got %h required %h", b,
                     dina[b*DL +: DL], e.data[i*DL +: DL]);
          end
          checks++;
          if (addra[b*AL +: AL] !== e.addr) begin
            errors++;
            $display("FAIL addra[%0d] got %0d required %0d", b,
                     addra[b*AL +: AL], e.addr);
          end
        end
        checks++;
        if (done !== e.last) begin
          errors++;
          $display("FAIL done_with_wea got %b required %b", done, e.last);
        end
      end
      if (wea[0]) log0.push_back(addra[0 +: AL]);
      if (wea[3]) log3.push_back(addra[3*AL +: AL]);
    end
  end

  function automatic logic [AL*XM-1:0] pack4(input int a0, input int a1,
                                             input int a2, input int a3);
    return {AL'(a3), AL'(a2), AL'(a1), AL'(a0)};
  endfunction

  task automatic send_cmd(input logic [AL*XM-1:0] sa, input int len);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_before_cmd got %b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    st_addr   = sa;
    linelen   = LL'(len);
    in_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    for (int j = 0; j < XM; j++) m_addr[j] = sa[j*AL +: AL];
    m_lane = 0;
    m_rem  = len;
    checks++;
    if (in_ready !== (len != 0)) begin
      errors++;
      $display("FAIL in_ready_after_cmd got %b required %b",
               in_ready, len != 0);
    end
  endtask

  task automatic send_beat(input bit gap);
    exp_t e;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_beat got %b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    e.lane = m_lane;
    e.addr = m_addr[m_lane];
    e.data = in_data;
    e.last = (m_rem == 1);
    q.push_back(e);
    m_addr[m_lane] = m_addr[m_lane] + AL'(1);
    m_lane = (m_lane + 1) % XM;
    m_rem  = m_rem - 1;
    @(negedge clk);
    in_valid = 1'b0;
    if (gap) begin
      @(negedge clk);
      checks++;
      if (wea !== '0) begin
        errors++;
        $display("FAIL gap_wea got %h required 0", wea);
      end
    end
  endtask

  task automatic check_end_of_line();
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got done=%b cmd_ready=%b required 1/0",
               done, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle got rdy=%b done=%b busy=%b required 1/0/0",
               cmd_ready, done, busy);
    end
  endtask

  task automatic check_log(input string nm, input logic [AL-1:0] got[$],
                           input int e0, input int e1);
    checks++;
    if (got.size() != 2 || got[0] !== AL'(e0) || got[1] !== AL'(e1)) begin
      errors++;
      $display("FAIL %s got n=%0d first=%0d second=%0d required %0d,%0d",
               nm, got.size(), got.size() > 0 ? got[0] : 0,
               got.size() > 1 ? got[1] : 0, e0, e1);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (wea !== '0 || dina !== '0 || addra !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got wea=%h done=%b required 0", wea, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (wea !== '0 || dina !== '0 || addra !== '0 || done !== 1'b0 ||
        busy !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got wea=%h busy=%b rdy=%b inr=%b",
               wea, busy, cmd_ready, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    log0.delete();
    log3.delete();
    send_cmd(pack4(10, 20, 30, 40), 8);
    for (int k = 0; k < 8; k++) send_beat(1'b0);
    check_end_of_line();
    check_log("b2b_lane0_addr", log0, 10, 11);
    check_log("b2b_lane3_addr", log3, 40, 41);
  endtask

  task automatic test_stall();
    log0.delete();
    log3.delete();
    send_cmd(pack4(10, 20, 30, 40), 8);
    for (int k = 0; k < 8; k++) begin
      send_beat(1'b0);
      if (k == 7) check_end_of_line();
      else begin
        @(negedge clk);
        checks++;
        if (wea !== '0 || done !== 1'b0) begin
          errors++;
          $display("FAIL stall_gap got wea=%h done=%b required 0",
                   wea, done);
        end
      end
    end
    check_log("stall_lane0_addr", log0, 10, 11);
    check_log("stall_lane3_addr", log3, 40, 41);
  endtask

  task automatic test_zero_len();
    send_cmd(pack4(1, 2, 3, 4), 0);
    checks++;
    if (done !== 1'b1 || wea !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_len got done=%b wea=%h inr=%b required 1/0/0",
               done, wea, in_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_idle got done=%b rdy=%b inr=%b",
               done, cmd_ready, in_ready);
    end
  endtask

  task automatic test_addr_wrap();
    log0.delete();
    send_cmd(pack4(8191, 1, 2, 3), 5);
    for (int k = 0; k < 5; k++) send_beat(1'b0);
    check_end_of_line();
    check_log("wrap_lane0_addr", log0, 8191, 0);
  endtask

  task automatic test_reset_mid_line();
    send_cmd(pack4(100, 200, 300, 400), 8);
    for (int k = 0; k < 3; k++) send_beat(1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wea !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got wea=%h busy=%b required 0/0", wea, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    log0.delete();
    send_cmd(pack4(500, 600, 700, 800), 1);
    send_beat(1'b0);
    check_end_of_line();
    checks++;
    if (log0.size() != 1 || log0[0] !== AL'(500)) begin
      errors++;
      $display("FAIL restart_lane0 got n=%0d addr=%0d required 1/500",
               log0.size(), log0.size() > 0 ? log0[0] : 0);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_zero_len();
    test_addr_wrap();
    test_reset_mid_line();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
